char_mem_scheduler: RTL
=======================

Name: char_mem_scheduler

Overview:
- Sequences the shared serial write/address bus of the 36-glyph character memory array.
- Arbitrates that bus between VGA scanout lookups, which have priority during active video, and glyph-upload requests from the host/SPI side.
- An upload delivers a 16-bit 4x4 pattern, serialised as 16 single-bit writes, and runs only while the scanout owner is idle (blanking).
- Sits between the VGA timing/pixel path, the command decoder and the char memory array.

Parameters:
- GLYPH_W, 4, glyph columns (mem_x range 0..GLYPH_W-1).
- GLYPH_H, 4, glyph rows (mem_y range 0..GLYPH_H-1; mem_y is 3 bits wide).
- NCHAR, 36, number of glyph instances on mem_rdata.

Ports:
- clock  in  1  system clock; all logic on rising edge.
- rst  in  1  asynchronous, active-high reset.
- video_active  in  1  1 = scanout owns the bus this cycle.
- rd_x  in  2  scanout column within glyph.
- rd_y  in  3  scanout row within glyph.
- wr_valid  in  1  upload request.
- wr_ready  out  1  upload accepted this cycle (valid&ready handshake).
- wr_pattern  in  16  glyph bits; bit index = y*4+x.
- wr_char  in  6  glyph index 0..NCHAR-1; used only by the verify feature.
- mem_write  out  1  to array write.
- mem_x  out  2  to array x.
- mem_y  out  3  to array y.
- mem_data  out  1  to array data_in.
- mem_rdata  in  36  from array data_out.
- busy  out  1  upload in progress.
- wr_done  out  1  one-cycle pulse when an upload completes.
- verify_err  out  1  sticky readback mismatch flag (feature-dependent).

Behaviour:
- Reset values: mem_write=0, mem_x=0, mem_y=0, mem_data=0, wr_ready=0, busy=0, wr_done=0, verify_err=0. State=IDLE, idx=0, pattern register=0.
- All mem_* outputs are registered. Values selected in cycle N appear in cycle N+1.
- Scanout path: when video_active=1, the next mem_x/mem_y = rd_x/rd_y and the next mem_write=0, regardless of state. Scanout read latency through this block is 1 cycle.
- State IDLE:
  - wr_ready = !video_active (combinational).
  - On wr_valid & wr_ready: latch wr_pattern and wr_char, set idx=0, busy=1, go to WRITE.
  - When video_active=0 and no upload is accepted, mem_x/mem_y hold their last value and mem_write=0.
- State WRITE (cycles with video_active=0):
  - Next mem_write=1, mem_x=idx[1:0], mem_y={1'b0,idx[3:2]}, mem_data=pattern[idx].
  - idx increments each such cycle.
  - After issuing idx=15: pulse wr_done, busy=0, go to IDLE (or VERIFY when the feature is enabled).
- WRITE with video_active=1: the upload pauses. idx is held, no write is issued, and the upload resumes at the same idx once video_active drops. An upload is never dropped because of pausing.
- Minimum upload time: 16 cycles of video_active=0, plus 1 cycle of output latency.
- wr_ready stays 0 whenever state is not IDLE. Only one upload is in flight at a time.
- A wr_valid and video_active rise in the same cycle: video_active wins and the request is not accepted.
- rst mid-upload: immediately returns to IDLE and drives mem_write=0. The partial glyph stays in memory as written. No wr_done pulse.
- idx is a 4-bit counter and never wraps in normal operation. Leaving WRITE happens on idx==15.

Optional Feature:
- Macro: CHAR_MEM_WR_VERIFY_EN.
- Enabled:
  - After the final write, enter VERIFY instead of IDLE. wr_done is deferred until the end of VERIFY, and busy stays 1.
  - VERIFY re-walks idx 0..15 with mem_write=0, pausing under video_active exactly as WRITE does.
  - One cycle after each address is presented, compare mem_rdata[wr_char] with pattern[idx]. On a mismatch, set verify_err=1.
  - verify_err clears only on rst.
  - After the final compare: pulse wr_done and go to IDLE.
  - A wr_char value of NCHAR or above sets verify_err at upload accept, and the write proceeds anyway.
- Disabled: no VERIFY state, wr_char and mem_rdata are ignored, and verify_err is tied to 0.

Test Plan:
- Reset check: assert rst for 3 cycles, then release -> all outputs 0, wr_ready=1 once video_active=0.
- Clean upload, video_active=0 throughout: wr_pattern=16'hA5C3 -> 16 consecutive mem_write=1 cycles, where the cycle with (x=1,y=0) carries data 1 and (x=2,y=0) carries data 0. wr_done appears 1 cycle after the last write; total 17 cycles from accept.
- Pause and resume: assert video_active for 10 cycles after idx=5 has been issued -> scanout addresses pass through with 1-cycle latency and mem_write=0. Writes resume at idx=6, and the total write count is exactly 16.
- Rejection: wr_valid=1 while video_active=1, or while busy -> wr_ready=0 and no writes are issued. Deassert video_active -> the request is accepted on the next cycle.
- Reset mid-upload: assert rst after 8 writes -> mem_write drops immediately, busy=0, no wr_done pulse. A new upload of 16'hFFFF then completes normally.
- With CHAR_MEM_WR_VERIFY_EN, wr_char=3, array model corrupting bit 7 -> verify_err=1 after VERIFY and wr_done is still pulsed. A correct model leaves verify_err=0.

Source files
------------

// File: rtl/char_mem_scheduler.sv
// char_mem_scheduler
//   Owns the shared serial write/address bus of the 36-glyph character
//   memory array. VGA scanout lookups take the bus whenever video_active is
//   high. Host glyph uploads are serialised into 16 single-bit writes during
//   blanking. An upload pauses under active video and resumes from the same
//   bit. All mem_* outputs are registered, so they have one cycle of latency.
//
//   Optional build macro: CHAR_MEM_WR_VERIFY_EN
//     When defined, each upload is followed by a readback pass. That pass
//     compares mem_rdata[wr_char] against the uploaded pattern and sets the
//     sticky verify_err flag on any mismatch. When undefined, wr_char and
//     mem_rdata are ignored and verify_err is tied to 0.
//
//   Ports
//     clock, rst            rising-edge clock, async active-high reset
//     video_active          scanout owns the bus this cycle
//     rd_x, rd_y            scanout column/row within the glyph
//     wr_valid, wr_ready    upload handshake (wr_ready is combinational)
//     wr_pattern, wr_char   glyph bits (bit = y*4+x) and glyph index
//     mem_write/x/y/data    registered array write/address bus
//     mem_rdata             array read data, one bit per glyph
//     busy, wr_done         upload in progress / one-cycle completion pulse
//     verify_err            sticky readback mismatch flag
module char_mem_scheduler #(
  parameter int GLYPH_W = 4,
  parameter int GLYPH_H = 4,
  parameter int NCHAR   = 36
) (
  input  logic             clock,
  input  logic             rst,
  input  logic             video_active,
  input  logic [1:0]       rd_x,
  input  logic [2:0]       rd_y,
  input  logic             wr_valid,
  output logic             wr_ready,
  input  logic [15:0]      wr_pattern,
  input  logic [5:0]       wr_char,
  output logic             mem_write,
  output logic [1:0]       mem_x,
  output logic [2:0]       mem_y,
  output logic             mem_data,
  input  logic [NCHAR-1:0] mem_rdata,
  output logic             busy,
  output logic             wr_done,
  output logic             verify_err
);

  localparam logic [3:0] LAST_IDX = 4'(GLYPH_W * GLYPH_H - 1);

`ifdef CHAR_MEM_WR_VERIFY_EN
  typedef enum logic [1:0] {IDLE, WRITE, VERIFY} state_t;
  localparam logic [5:0] NCHAR_IDX = 6'(NCHAR);
`else
  typedef enum logic [1:0] {IDLE, WRITE} state_t;
`endif

  state_t      state, state_d;
  logic [3:0]  idx, idx_d;
  logic [15:0] pat, pat_d;
  logic        fin_q, fin_d;
  logic        write_d, data_d, busy_d, done_d;
  logic [1:0]  x_d;
  logic [2:0]  y_d;
  logic        accept;

`ifdef CHAR_MEM_WR_VERIFY_EN
  logic [5:0]  char_q, char_d;
  logic        cmp_q, cmp_d;
  logic        exp_q, exp_d;
  logic        err_d;
`else
  logic        unused_inputs;
  assign unused_inputs = ^{wr_char, mem_rdata};
  assign verify_err    = 1'b0;
`endif

  assign wr_ready = (state == IDLE) && !video_active && !rst;
  assign accept   = wr_valid && wr_ready;

  always_comb begin
    state_d = state;
    idx_d   = idx;
    pat_d   = pat;
    fin_d   = 1'b0;
    write_d = 1'b0;
    x_d     = mem_x;
    y_d     = mem_y;
    data_d  = mem_data;
    busy_d  = busy;
    // wr_done trails the final bus cycle by one, in line with the array read latency
    done_d  = fin_q;
`ifdef CHAR_MEM_WR_VERIFY_EN
    char_d  = char_q;
    cmp_d   = 1'b0;
    exp_d   = exp_q;
    err_d   = verify_err;
`endif

    if (video_active) begin
      x_d = rd_x;
      y_d = rd_y;
    end

    case (state)
      IDLE: begin
        if (accept) begin
          pat_d   = wr_pattern;
          idx_d   = '0;
          busy_d  = 1'b1;
          state_d = WRITE;
`ifdef CHAR_MEM_WR_VERIFY_EN
          char_d  = wr_char;
          if (wr_char >= NCHAR_IDX) err_d = 1'b1;
`endif
        end
      end
      WRITE: begin
        if (!video_active) begin
          write_d = 1'b1;
          x_d     = idx[1:0];
          y_d     = {1'b0, idx[3:2]};
          data_d  = pat[idx];
          if (idx == LAST_IDX) begin
            idx_d   = '0;
`ifdef CHAR_MEM_WR_VERIFY_EN
            state_d = VERIFY;
`else
            state_d = IDLE;
            busy_d  = 1'b0;
            fin_d   = 1'b1;
`endif
          end else begin
            idx_d = idx + 4'd1;
          end
        end
      end
`ifdef CHAR_MEM_WR_VERIFY_EN
      VERIFY: begin
        if (!video_active) begin
          x_d   = idx[1:0];
          y_d   = {1'b0, idx[3:2]};
          cmp_d = 1'b1;
          exp_d = pat[idx];
          if (idx == LAST_IDX) begin
            idx_d   = '0;
            state_d = IDLE;
            busy_d  = 1'b0;
            fin_d   = 1'b1;
          end else begin
            idx_d = idx + 4'd1;
          end
        end
      end
`endif
      default: state_d = IDLE;
    endcase

`ifdef CHAR_MEM_WR_VERIFY_EN
    // mem_rdata reflects the address registered on the previous edge
    if (cmp_q && (char_q < NCHAR_IDX) && (mem_rdata[char_q] != exp_q)) err_d = 1'b1;
`endif
  end

  always_ff @(posedge clock or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      idx       <= '0;
      pat       <= '0;
      fin_q     <= 1'b0;
      mem_write <= 1'b0;
      mem_x     <= '0;
      mem_y     <= '0;
      mem_data  <= 1'b0;
      busy      <= 1'b0;
      wr_done   <= 1'b0;
    end else begin
      state     <= state_d;
      idx       <= idx_d;
      pat       <= pat_d;
      fin_q     <= fin_d;
      mem_write <= write_d;
      mem_x     <= x_d;
      mem_y     <= y_d;
      mem_data  <= data_d;
      busy      <= busy_d;
      wr_done   <= done_d;
    end
  end

`ifdef CHAR_MEM_WR_VERIFY_EN
  always_ff @(posedge clock or posedge rst) begin
    if (rst) begin
      char_q     <= '0;
      cmp_q      <= 1'b0;
      exp_q      <= 1'b0;
      verify_err <= 1'b0;
    end else begin
      char_q     <= char_d;
      cmp_q      <= cmp_d;
      exp_q      <= exp_d;
      verify_err <= err_d;
    end
  end
`endif

endmodule
